instr_fetch_unit: RTL

// - IF stage of the RV64I pipeline: holds the PC, issues 32-bit fetches to instruction memory,
//   and delivers {instr, pc, pc+4} to the decode/control stage.
// - Takes redirects from the control/execute side: PCSrc plus a branch/JAL/JALR target.
// - Max one outstanding imem request. A redirect squashes the in-flight fetch and the IF/ID slot.

---
 rtl/rv_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 33 +++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV64I pipeline types and constants
package rv_pkg;
  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {IF_REQ, IF_WAIT, IF_HOLD} if_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } if_slot_t;
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry instruction/pc holding register with load and clear
module fetch_buffer
  import rv_pkg::*;
#(
  parameter if_slot_t RST_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  logic     clear_i,
  input  if_slot_t data_i,
  output logic     valid_o,
  output if_slot_t data_o
);
  logic     valid_q;
  if_slot_t data_q;

  // Load wins over clear; clearing only drops valid, the payload is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV64I IF stage: PC, single-outstanding imem fetch, IF/ID slot
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0]     NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_pc_plus4_o
);
  localparam if_slot_t SLOT_RST = '{instr: NOP, pc: RESET_PC};

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic            started_q;

  logic            hs;
  logic [XLEN-1:0] redirect_tgt;
  logic            slot_load, slot_clear, slot_valid;
  logic            buf_load, buf_clear, buf_valid;
  if_slot_t        slot_in, slot_data, buf_data, rsp_entry;

  assign hs           = imem_req_valid & imem_req_ready;
  assign redirect_tgt = redirect_pc_i & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign rsp_entry    = '{instr: imem_rsp_data, pc: pc_q};

  // started_q holds the request off for the cycle in which reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IF_REQ;
      pc_q      <= RESET_PC;
      squash_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      squash_q  <= squash_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    slot_load  = 1'b0;
    slot_clear = redirect_i | ~stall_i;
    slot_in    = rsp_entry;
    buf_load   = 1'b0;
    buf_clear  = redirect_i;
    if (redirect_i) begin
      pc_d     = redirect_tgt;
      state_d  = IF_REQ;
      squash_d = 1'b0;
      // An accepted-but-unanswered fetch is now stale and must be dropped on arrival.
      case (state_q)
        IF_REQ:  if (hs) begin squash_d = 1'b1; state_d = IF_WAIT; end
        IF_WAIT: if (!imem_rsp_valid) begin squash_d = 1'b1; state_d = IF_WAIT; end
        default: ;
      endcase
    end else begin
      case (state_q)
        IF_REQ: if (hs) state_d = IF_WAIT;
        IF_WAIT: begin
          if (imem_rsp_valid) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = IF_REQ;
            end else if (!slot_valid || !stall_i) begin
              slot_load = 1'b1;
              pc_d      = pc_q + XLEN'(4);
              state_d   = IF_REQ;
            end else begin
              buf_load = 1'b1;
              state_d  = IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (!stall_i && buf_valid) begin
            slot_load = 1'b1;
            slot_in   = buf_data;
            buf_clear = 1'b1;
            pc_d      = pc_q + XLEN'(4);
            state_d   = IF_REQ;
          end
        end
        default: state_d = IF_REQ;
      endcase
    end
  end

  fetch_buffer #(.RST_VAL(SLOT_RST)) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (rsp_entry),
    .valid_o (buf_valid),
    .data_o  (buf_data)
  );

  fetch_buffer #(.RST_VAL(SLOT_RST)) u_ifid_slot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (slot_load),
    .clear_i (slot_clear),
    .data_i  (slot_in),
    .valid_o (slot_valid),
    .data_o  (slot_data)
  );

  assign imem_req_valid = started_q & (state_q == IF_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid_o     = slot_valid;
  assign if_instr_o     = slot_valid ? slot_data.instr : NOP;
  assign if_pc_o        = slot_data.pc;
  assign if_pc_plus4_o  = slot_data.pc + XLEN'(4);
endmodule
